// File: rtl/pll_lock_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pll_lock_sequencer
//  Description : Sequences the system PLL out of reset and holds downstream
//                logic in reset until the PLL's lock has been stable for a
//                programmed number of reference-clock cycles. A lock timeout
//                re-resets the PLL up to a retry limit, then parks in a
//                sticky failure state. A loss of lock while running
//                re-asserts system reset and counts the event.
//                Clocked only from the free-running board reference, so no
//                logic here depends on a PLL output clock.
//
//  Ports       : clk          - 50 MHz reference (same net as PLL refclk)
//                reset_n      - synchronous active-low reset
//                pll_locked   - PLL lock flag, asynchronous to clk
//                clear_fail   - one-cycle pulse, leaves FAILED
//                pll_rst      - PLL reset, active high
//                sys_reset_n  - downstream synchronous active-low reset
//                lock_ok      - high while in RUN
//                lock_fail    - sticky retry-exhausted flag
//                retry_count  - retries used in the current episode
//                loss_count   - lock-loss events, saturating at 255
//
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_sequencer #(
   parameter int SYNC_STAGES         = 2,
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int MAX_RETRIES         = 3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       pll_locked,
   input  logic       clear_fail,
   output logic       pll_rst,
   output logic       sys_reset_n,
   output logic       lock_ok,
   output logic       lock_fail,
   output logic [((MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1) - 1:0] retry_count,
   output logic [7:0] loss_count
);

   // Counter widths; a limit of 1 still needs a 1-bit counter.
   localparam int C_RETRY_W  = (MAX_RETRIES > 0)         ? $clog2(MAX_RETRIES + 1)    : 1;
   localparam int C_RST_W    = (PLL_RST_CYCLES > 1)      ? $clog2(PLL_RST_CYCLES)     : 1;
   localparam int C_STABLE_W = (LOCK_STABLE_CYCLES > 1)  ? $clog2(LOCK_STABLE_CYCLES) : 1;
   localparam int C_TMO_W    = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES): 1;

   localparam logic [C_RST_W-1:0]    C_RST_LAST    = C_RST_W'(PLL_RST_CYCLES - 1);
   localparam logic [C_STABLE_W-1:0] C_STABLE_LAST = C_STABLE_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [C_TMO_W-1:0]    C_TMO_LAST    = C_TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [C_RETRY_W-1:0]  C_RETRY_MAX   = C_RETRY_W'(MAX_RETRIES);

   typedef enum logic [2:0] {
      ST_RESET_PLL = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABILIZE = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAILED    = 3'd4
   } state_t;

   state_t                  r_state;
   logic [SYNC_STAGES-1:0]  r_sync;
   logic [C_RST_W-1:0]      r_rst_cnt;
   logic [C_STABLE_W-1:0]   r_stable_cnt;
   logic [C_TMO_W-1:0]      r_tmo_cnt;
   logic [C_RETRY_W-1:0]    r_retry_count;
   logic [7:0]              r_loss_count;
   logic                    r_pll_rst;
   logic                    r_sys_reset_n;
   logic                    r_lock_ok;
   logic                    r_lock_fail;

   logic w_locked_s;
   logic w_tmo_hit;
   logic w_retry_done;

   // pll_locked is asynchronous: only the last synchronizer stage is used.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
      end
   end

   assign w_locked_s   = r_sync[SYNC_STAGES-1];
   assign w_tmo_hit    = (r_tmo_cnt == C_TMO_LAST);
   assign w_retry_done = (r_retry_count == C_RETRY_MAX);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state       <= ST_RESET_PLL;
         r_rst_cnt     <= '0;
         r_stable_cnt  <= '0;
         r_tmo_cnt     <= '0;
         r_retry_count <= '0;
         r_loss_count  <= '0;
         r_pll_rst     <= 1'b1;
         r_sys_reset_n <= 1'b0;
         r_lock_ok     <= 1'b0;
         r_lock_fail   <= 1'b0;
      end else begin
         case (r_state)
            ST_RESET_PLL: begin
               if (r_rst_cnt == C_RST_LAST) begin
                  r_state   <= ST_WAIT_LOCK;
                  r_rst_cnt <= '0;
                  r_pll_rst <= 1'b0;
               end else begin
                  r_rst_cnt <= r_rst_cnt + 1'b1;
               end
            end

            // Both lock-acquisition states share the timeout, and the
            // timeout takes priority over any lock progress.
            ST_WAIT_LOCK, ST_STABILIZE: begin
               if (w_tmo_hit) begin
                  r_stable_cnt <= '0;
                  r_pll_rst    <= 1'b1;
                  if (w_retry_done) begin
                     r_state     <= ST_FAILED;
                     r_lock_fail <= 1'b1;
                  end else begin
                     r_state       <= ST_RESET_PLL;
                     r_retry_count <= r_retry_count + 1'b1;
                     r_tmo_cnt     <= '0;
                  end
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
                  if (r_state == ST_WAIT_LOCK) begin
                     if (w_locked_s) begin
                        r_state      <= ST_STABILIZE;
                        r_stable_cnt <= '0;
                     end
                  end else if (!w_locked_s) begin
                     // Chatter restarts the stability window but not the
                     // overall timeout.
                     r_state      <= ST_WAIT_LOCK;
                     r_stable_cnt <= '0;
                  end else if (r_stable_cnt == C_STABLE_LAST) begin
                     r_state       <= ST_RUN;
                     r_stable_cnt  <= '0;
                     r_sys_reset_n <= 1'b1;
                     r_lock_ok     <= 1'b1;
                  end else begin
                     r_stable_cnt <= r_stable_cnt + 1'b1;
                  end
               end
            end

            ST_RUN: begin
               if (!w_locked_s) begin
                  r_state       <= ST_RESET_PLL;
                  r_tmo_cnt     <= '0;
                  r_retry_count <= '0;
                  r_pll_rst     <= 1'b1;
                  r_sys_reset_n <= 1'b0;
                  r_lock_ok     <= 1'b0;
                  if (r_loss_count != 8'hFF) begin
                     r_loss_count <= r_loss_count + 1'b1;
                  end
               end
            end

            ST_FAILED: begin
               if (clear_fail) begin
                  r_state       <= ST_RESET_PLL;
                  r_tmo_cnt     <= '0;
                  r_retry_count <= '0;
                  r_lock_fail   <= 1'b0;
               end
            end

            default: begin
               r_state       <= ST_RESET_PLL;
               r_rst_cnt     <= '0;
               r_tmo_cnt     <= '0;
               r_stable_cnt  <= '0;
               r_pll_rst     <= 1'b1;
               r_sys_reset_n <= 1'b0;
               r_lock_ok     <= 1'b0;
            end
         endcase
      end
   end

   assign pll_rst     = r_pll_rst;
   assign sys_reset_n = r_sys_reset_n;
   assign lock_ok     = r_lock_ok;
   assign lock_fail   = r_lock_fail;
   assign retry_count = r_retry_count;
   assign loss_count  = r_loss_count;

endmodule
`default_nettype wire

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Controller for the opposite side of the system PLL's refclk/rst/locked interface.
- Drives the PLL reset and watches its asynchronous locked flag.
- Holds downstream logic in reset until lock has been stable for a programmed time.
- On lock timeout it re-resets the PLL, up to a retry limit. On loss of lock it re-asserts system reset.
- Runs on the free-running 50 MHz board reference, so it never depends on a PLL output clock.

Parameters:
- SYNC_STAGES, 2: flops in the pll_locked synchronizer (minimum 2).
- PLL_RST_CYCLES, 16: clk cycles pll_rst is held high per reset attempt (minimum 1).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before reset release (minimum 1).
- LOCK_TIMEOUT_CYCLES, 65536: cycles allowed from PLL reset release to reaching RUN.
- MAX_RETRIES, 3: re-reset attempts after the first before declaring failure (minimum 0).

Ports:
- clk  in  1  50 MHz reference clock, the same net as the PLL refclk.
- reset_n  in  1  synchronous, active-low reset.
- pll_locked  in  1  PLL locked flag, asynchronous to clk.
- clear_fail  in  1  single-cycle pulse; leaves FAILED.
- pll_rst  out  1  PLL reset, active high.
- sys_reset_n  out  1  downstream synchronous active-low reset.
- lock_ok  out  1  high while in RUN.
- lock_fail  out  1  sticky retry-exhausted flag.
- retry_count  out  $clog2(MAX_RETRIES+1)  retries used in the current episode.
- loss_count  out  8  lock-loss events, saturating at 255.

Behaviour:
- Only clk is used; all outputs are registered and change only on clk edges.
- Reset: while reset_n=0 at an edge, state goes to RESET_PLL with all counters 0. Outputs: pll_rst=1, sys_reset_n=0, lock_ok=0, lock_fail=0, retry_count=0, loss_count=0. Reset has the same effect from any state, mid-operation included.
- Synchronizer: pll_locked passes through a SYNC_STAGES flop chain to give locked_s. The FSM uses only locked_s.
- Timeout counter: cleared on entry to RESET_PLL; increments every cycle in WAIT_LOCK and STABILIZE.
- RESET_PLL:
  - Outputs: pll_rst=1, sys_reset_n=0, lock_ok=0.
  - Stays exactly PLL_RST_CYCLES cycles, then goes to WAIT_LOCK.
- WAIT_LOCK:
  - Outputs: pll_rst=0, sys_reset_n=0.
  - locked_s=1 -> STABILIZE, stable counter=0.
  - Timeout counter reaching LOCK_TIMEOUT_CYCLES-1 -> FAILED if retry_count==MAX_RETRIES; otherwise retry_count+1 and RESET_PLL.
  - If timeout and lock occur in the same cycle, timeout wins.
- STABILIZE:
  - Outputs: pll_rst=0, sys_reset_n=0.
  - locked_s=0 -> WAIT_LOCK; stable counter cleared, timeout counter kept.
  - locked_s=1 with stable counter==LOCK_STABLE_CYCLES-1 -> RUN; otherwise the counter increments.
  - Timeout applies here exactly as in WAIT_LOCK, with priority over reaching RUN.
- RUN:
  - Outputs: sys_reset_n=1, lock_ok=1, pll_rst=0.
  - locked_s=0 -> RESET_PLL: retry_count cleared, loss_count increments (saturating at 255).
  - sys_reset_n and lock_ok drop on that same edge.
- FAILED:
  - Outputs: pll_rst=1, sys_reset_n=0, lock_fail=1.
  - clear_fail=1 -> RESET_PLL with lock_fail=0 and retry_count=0.
  - clear_fail is ignored in every other state.
- Latency, taking the first edge that samples pll_locked=1 as edge 0:
  - sys_reset_n rises at edge SYNC_STAGES+LOCK_STABLE_CYCLES (1026 at defaults).
  - Loss of lock: sys_reset_n falls at edge SYNC_STAGES after the first edge that samples pll_locked=0.
- Counter widths: sized with $clog2 of each limit. No wrap is possible, because every counter is bounded by a state transition.

Test Plan:
1. Lock after reset (defaults): reset_n low 4 cycles, then high; pll_locked rises 100 cycles after pll_rst falls -> pll_rst high exactly 16 cycles; sys_reset_n and lock_ok rise at edge 1026 after lock is sampled; retry_count=0.
2. Chatter: locked high 500 cycles, low 1 cycle, high again -> sys_reset_n stays 0; release comes 1026 edges after the second rise; no retry.
3. Timeout and retry (LOCK_TIMEOUT_CYCLES=64, MAX_RETRIES=3): pll_locked held 0 -> 4 pll_rst pulses of 16 cycles; retry_count steps 1, 2, 3; then lock_fail=1 and pll_rst held high. clear_fail pulse -> lock_fail=0, retry_count=0, new 16-cycle pulse.
4. Loss of lock in RUN: drop pll_locked -> sys_reset_n and lock_ok fall 2 edges later; loss_count=1; pll_rst high 16 cycles; relock gives a normal release.
5. Saturation: 260 loss/relock cycles (LOCK_STABLE_CYCLES=4) -> loss_count stops at 255.
6. Mid-operation reset: assert reset_n low during STABILIZE and during FAILED -> next edge gives pll_rst=1, sys_reset_n=0, lock_fail=0, both counts 0.
